// File: rtl/taxi_axis_gmii_rx_lenchk.sv
// -----------------------------------------------------------------------------
// taxi_axis_gmii_rx_lenchk
// GMII/MII frame receiver with runtime length policing. It strips the
// preamble and SFD, checks the CRC-32 FCS and strips it, polices the minimum
// and maximum frame length, and emits each frame on a flattened AXI4-Stream
// source. tuser[0] marks a bad frame on the tlast beat.
//
// Optional build macro: TAXI_GMII_RX_LENCHK_VLAN_EN
//   When defined, the maximum length limit is raised by 4 for frames whose
//   bytes 12-13 carry the 802.1Q TPID 0x8100.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   gmii_rxd/_rx_dv/_rx_er   GMII/MII receive inputs
//   m_axis_rx_*              AXI4-Stream source (tready is ignored)
//   ptp_ts                   free-running PTP time, captured at SFD
//   clk_enable               qualifies every input sample
//   mii_select               1 = MII nibbles on gmii_rxd[3:0], low nibble first
//   cfg_rx_enable            0 = drop frames (sampled at SFD)
//   cfg_rx_min_pkt_len       minimum frame length incl. FCS
//   cfg_rx_max_pkt_len       maximum frame length incl. FCS
//   start_packet             pulse on SFD acceptance
//   error_*                  per-frame status pulses, aligned with tlast
//   frame_len                length incl. FCS of the last frame, held
// -----------------------------------------------------------------------------
module taxi_axis_gmii_rx_lenchk #(
   parameter int DATA_W    = 8,
   parameter bit PTP_TS_EN = 1'b0,
   parameter int PTP_TS_W  = 96,
   parameter int MAX_LEN_W = 14,
   localparam int USER_W   = (PTP_TS_EN ? PTP_TS_W : 0) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_W-1:0]     gmii_rxd,
   input  logic                  gmii_rx_dv,
   input  logic                  gmii_rx_er,
   output logic [DATA_W-1:0]     m_axis_rx_tdata,
   output logic                  m_axis_rx_tvalid,
   input  logic                  m_axis_rx_tready,
   output logic                  m_axis_rx_tlast,
   output logic [USER_W-1:0]     m_axis_rx_tuser,
   input  logic [PTP_TS_W-1:0]   ptp_ts,
   input  logic                  clk_enable,
   input  logic                  mii_select,
   input  logic                  cfg_rx_enable,
   input  logic [6:0]            cfg_rx_min_pkt_len,
   input  logic [MAX_LEN_W-1:0]  cfg_rx_max_pkt_len,
   output logic                  start_packet,
   output logic                  error_bad_frame,
   output logic                  error_bad_fcs,
   output logic                  error_runt,
   output logic                  error_oversize,
   output logic [MAX_LEN_W-1:0]  frame_len
);

   if (DATA_W != 8) begin : g_bad_width
      $fatal(1, "taxi_axis_gmii_rx_lenchk: DATA_W must be 8");
   end

   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

   typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_PAYLOAD, ST_DROP} state_t;

   // Reflected CRC-32 (poly 0xEDB88320), one byte, no final inversion.
   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] x;
      x = c;
      for (int i = 0; i < 8; i++) begin
         x = (x[0] ^ d[i]) ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
      end
      return x;
   endfunction

   state_t                r_state, w_state_next;
   logic [3:0]            r_nib;
   logic                  r_nib_er, r_nib_pend;
   logic [DATA_W-1:0]     r_dly [0:4];
   logic [31:0]           r_crc;
   logic [MAX_LEN_W-1:0]  r_len, r_out_cnt, r_frame_len;
   logic                  r_er_seen;
   logic [DATA_W-1:0]     r_tdata;
   logic                  r_tvalid, r_tlast, r_bad;
   logic                  r_start, r_err_fcs, r_err_runt, r_err_over;

   logic                  w_slot, w_dv, w_er, w_odd;
   logic [DATA_W-1:0]     w_byte;
   logic                  w_sfd, w_shift, w_emit, w_last, w_bad;
   logic                  w_fcs_bad, w_runt, w_over;
   logic [MAX_LEN_W-1:0]  w_len_inc, w_frame_len;
   logic [MAX_LEN_W:0]    w_limit;
   logic                  w_unused;

   assign w_unused  = ^{m_axis_rx_tready, ptp_ts};
   assign w_len_inc = (&r_len) ? r_len : r_len + MAX_LEN_W'(1);

`ifdef TAXI_GMII_RX_LENCHK_VLAN_EN
   logic r_tpid_hi, r_vlan;
   always_ff @(posedge clk) begin
      if (rst || w_sfd) begin
         r_tpid_hi <= 1'b0;
         r_vlan    <= 1'b0;
      end else if (w_shift) begin
         if (r_len == MAX_LEN_W'(12)) r_tpid_hi <= (w_byte == 8'h81);
         if (r_len == MAX_LEN_W'(13)) r_vlan    <= r_tpid_hi && (w_byte == 8'h00);
      end
   end
   assign w_limit = {1'b0, cfg_rx_max_pkt_len} + (r_vlan ? (MAX_LEN_W+1)'(4) : '0);
`else
   assign w_limit = {1'b0, cfg_rx_max_pkt_len};
`endif

   // Byte-slot formation: in MII mode a slot exists only once a nibble pair
   // is complete; a dv-low sample is always a slot so frame end is seen.
   always_comb begin
      w_slot = 1'b0;
      w_dv   = 1'b0;
      w_byte = '0;
      w_er   = 1'b0;
      w_odd  = 1'b0;
      if (clk_enable) begin
         if (mii_select) begin
            if (gmii_rx_dv) begin
               if (r_nib_pend) begin
                  w_slot = 1'b1;
                  w_dv   = 1'b1;
                  w_byte = {gmii_rxd[3:0], r_nib};
                  w_er   = gmii_rx_er | r_nib_er;
               end
            end else begin
               w_slot = 1'b1;
               w_odd  = r_nib_pend;
            end
         end else begin
            w_slot = 1'b1;
            w_dv   = gmii_rx_dv;
            w_byte = gmii_rxd;
            w_er   = gmii_rx_er;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_nib      <= '0;
         r_nib_er   <= 1'b0;
         r_nib_pend <= 1'b0;
      end else if (clk_enable && mii_select) begin
         if (gmii_rx_dv && !r_nib_pend) begin
            r_nib      <= gmii_rxd[3:0];
            r_nib_er   <= gmii_rx_er;
            r_nib_pend <= 1'b1;
         end else begin
            r_nib_pend <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_sfd        = 1'b0;
      w_shift      = 1'b0;
      w_emit       = 1'b0;
      w_last       = 1'b0;
      w_bad        = 1'b0;
      w_fcs_bad    = 1'b0;
      w_runt       = 1'b0;
      w_over       = 1'b0;
      w_frame_len  = r_len;
      if (w_slot) begin
         case (r_state)
            ST_IDLE: begin
               // dv with er in idle is a carrier event, not a frame
               if (w_dv && !w_er) w_state_next = (w_byte == 8'h55) ? ST_PREAMBLE : ST_DROP;
            end
            ST_PREAMBLE: begin
               if (!w_dv) begin
                  w_state_next = ST_IDLE;
               end else if (w_byte == 8'hD5 && cfg_rx_enable) begin
                  w_state_next = ST_PAYLOAD;
                  w_sfd        = 1'b1;
               end else if (w_byte != 8'h55) begin
                  w_state_next = ST_DROP;
               end
            end
            ST_PAYLOAD: begin
               if (w_dv) begin
                  w_shift = 1'b1;
                  // Once five bytes are held, the oldest is known not to be FCS.
                  if (r_len >= MAX_LEN_W'(5)) begin
                     w_emit = 1'b1;
                     if ({1'b0, r_out_cnt} == w_limit) begin
                        w_last       = 1'b1;
                        w_over       = 1'b1;
                        w_bad        = 1'b1;
                        w_frame_len  = w_len_inc;
                        w_state_next = ST_DROP;
                     end
                  end
               end else begin
                  w_state_next = ST_IDLE;
                  w_emit       = 1'b1;
                  w_last       = 1'b1;
                  w_fcs_bad    = (r_crc != CRC_RESIDUE);
                  w_runt       = (r_len < {{(MAX_LEN_W-7){1'b0}}, cfg_rx_min_pkt_len})
                               || (r_len < MAX_LEN_W'(5));
                  w_over       = ({1'b0, r_len} > w_limit);
                  w_bad        = w_fcs_bad | w_runt | w_over | r_er_seen | w_odd;
               end
            end
            default: begin
               if (!w_dv) w_state_next = ST_IDLE;
            end
         endcase
      end
   end

   // Payload delay line: stage 0 takes the new byte, the rest shift along.
   always_ff @(posedge clk) begin
      if (rst)          r_dly[0] <= '0;
      else if (w_shift) r_dly[0] <= w_byte;
   end

   for (genvar gi = 1; gi < 5; gi++) begin : g_dly
      always_ff @(posedge clk) begin
         if (rst)          r_dly[gi] <= '0;
         else if (w_shift) r_dly[gi] <= r_dly[gi-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_crc       <= 32'hFFFFFFFF;
         r_len       <= '0;
         r_out_cnt   <= '0;
         r_er_seen   <= 1'b0;
         r_tdata     <= '0;
         r_tvalid    <= 1'b0;
         r_tlast     <= 1'b0;
         r_bad       <= 1'b0;
         r_start     <= 1'b0;
         r_err_fcs   <= 1'b0;
         r_err_runt  <= 1'b0;
         r_err_over  <= 1'b0;
         r_frame_len <= '0;
      end else begin
         if (w_sfd) begin
            r_crc     <= 32'hFFFFFFFF;
            r_len     <= '0;
            r_out_cnt <= '0;
            r_er_seen <= 1'b0;
         end else if (w_shift) begin
            r_crc <= crc_step(r_crc, w_byte);
            r_len <= w_len_inc;
            if (w_er) r_er_seen <= 1'b1;
         end
         if (w_emit && !(&r_out_cnt)) r_out_cnt <= r_out_cnt + MAX_LEN_W'(1);
         if (w_emit) r_tdata <= (r_len >= MAX_LEN_W'(5)) ? r_dly[4] : '0;
         if (w_emit && w_last) r_frame_len <= w_frame_len;
         r_tvalid   <= w_emit;
         r_tlast    <= w_emit & w_last;
         r_bad      <= w_emit & w_last & w_bad;
         r_start    <= w_sfd;
         r_err_fcs  <= w_fcs_bad;
         r_err_runt <= w_runt;
         r_err_over <= w_over;
      end
   end

   if (PTP_TS_EN) begin : g_ptp
      logic [PTP_TS_W-1:0] r_ts;
      always_ff @(posedge clk) begin
         if (rst)        r_ts <= '0;
         else if (w_sfd) r_ts <= ptp_ts;
      end
      assign m_axis_rx_tuser = {r_ts, r_bad};
   end else begin : g_no_ptp
      assign m_axis_rx_tuser = r_bad;
   end

   assign m_axis_rx_tdata  = r_tdata;
   assign m_axis_rx_tvalid = r_tvalid;
   assign m_axis_rx_tlast  = r_tlast;
   assign start_packet     = r_start;
   assign error_bad_frame  = r_bad;
   assign error_bad_fcs    = r_err_fcs;
   assign error_runt       = r_err_runt;
   assign error_oversize   = r_err_over;
   assign frame_len        = r_frame_len;

endmodule
